mem_ctrl: RTL and testbench
===========================

# mem_ctrl

- Data-memory responder on the far side of the load/store path of the RISC-V pipeline's MEM stage.
- Accepts one load or store request at a time and serialises it into little-endian byte accesses on the byte-wide RAM port.
- Holds the pipeline via `stall_o` until the access completes.
- Returns loaded data zero- or sign-extended to 32 bits.

## Interface
- `RAM_ADDR_W`, 17: RAM byte-address width; request addresses are truncated to this width.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_i`  in  1  request valid; level, held stable until `done_o`
- `we_i`  in  1  1 = store, 0 = load
- `addr_i`  in  32  byte address
- `size_i`  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- `sign_i`  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- `wdata_i`  in  32  store data; low bytes used per size
- `rdata_o`  out  32  extended load data; valid while `done_o`=1
- `done_o`  out  1  one-cycle completion pulse
- `err_o`  out  1  misaligned request rejected; only with `MEM_CTRL_MISALIGN_TRAP_EN`
- `stall_o`  out  1  `req_i & ~done_o`, combinational
- `ram_a_o`  out  RAM_ADDR_W  RAM byte address
- `ram_dout_o`  out  8  RAM write data
- `ram_wr_o`  out  1  RAM write enable; write occurs at the clock edge
- `ram_din_i`  in  8  RAM read data; synchronous, valid the cycle after the address

## Operation
- **States:** IDLE, READ, WRITE, DONE. Byte counter `cnt` is 2 bits.
- **Request byte count:** n = 1, 2 or 4 from `size_i`.
- **IDLE:**
  - On `req_i`=1: latch `addr`, `size`, `sign` and `wdata`; clear `cnt`.
  - Go to READ or WRITE according to `we_i`.
- **WRITE:**
  - Each cycle drive `ram_a_o` = addr + cnt, `ram_dout_o` = wdata byte[cnt], `ram_wr_o`=1.
  - After byte n-1, go to DONE.
- **READ:**
  - Each cycle issue `ram_a_o` = addr + cnt.
  - On the following cycle, capture `ram_din_i` into result byte[cnt-1].
  - One extra capture cycle after the last issue; `ram_a_o` is don't-care during it.
  - Then go to DONE.
- **DONE:**
  - `done_o`=1; `rdata_o` = result extended per the latched size/sign. For stores, `rdata_o`=0.
  - Unconditionally return to IDLE. No request is accepted in the DONE cycle.
- **Address arithmetic:** addr + cnt is computed modulo 2^RAM_ADDR_W, so a word at the top of memory wraps to address 0. `addr_i` bits above `RAM_ADDR_W` are ignored.
- **Alignment:** misaligned addresses are legal by default; the byte-serial scheme makes alignment irrelevant.
- **Unused result bytes:** cleared to 0 before extension.
- **Reset values (async, `rst_n`=0):**
  - State IDLE, `cnt`=0.
  - `ram_wr_o`=0, `ram_a_o`=0, `ram_dout_o`=0.
  - `rdata_o`=0, `done_o`=0, `err_o`=0.
- **Reset mid-access:** the transfer is abandoned and the write enable drops immediately. A partially written store remains in RAM; this is accepted.

## Timing
- Store latency: n cycles in WRITE plus 1 DONE cycle. Byte store = 2 cycles from acceptance edge to `done_o`; word store = 5.
- Load latency: n+1 cycles in READ plus 1 DONE cycle. Byte load = 3; word load = 6.
- The MEM stage advances on the edge that ends the DONE cycle. The next request is accepted no earlier than the following IDLE cycle.
- `stall_o` is high in the request's first cycle, i.e. in IDLE before acceptance.
- `req_i` dropping mid-transfer is illegal. The transfer still completes and `done_o` still pulses.

## Configuration
- Macro: `MEM_CTRL_MISALIGN_TRAP_EN`.
- **Defined:**
  - A half request with addr[0]=1, or a word request with addr[1:0]≠0, performs no RAM access.
  - IDLE goes straight to DONE with `err_o`=1 and `rdata_o`=0.
  - `err_o` is valid only alongside `done_o`.
- **Undefined:**
  - Misaligned accesses are performed byte-wise.
  - `err_o` is tied to 0.

## Structure
- **Shared package `mem_ctrl_pkg`:**
  - Size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`.
  - State enum.
  - `RAM_ADDR_W` default.
- **Sub-module `load_ext`:** combinational; inputs 32-bit raw result, size and sign; output extended `rdata_o`. Reusable by a later cache path.

## Test plan
- Word store of 0xDEADBEEF at 0x00100 -> `ram_wr_o` high 4 cycles at 0x100..0x103 with data EF, BE, AD, DE; `done_o` on cycle 5.
- Word load from 0x00100 after the above, `sign_i`=0 -> `done_o` on cycle 6 with `rdata_o`=0xDEADBEEF.
- Byte load from 0x00103 with `sign_i`=1 -> 0xFFFFFFDE. With `sign_i`=0 -> 0x000000DE. Half load from 0x00102, `sign_i`=1 -> 0xFFFFDEAD.
- Word store of 0x11223344 at 0x1FFFE -> RAM writes 0x1FFFE=44, 0x1FFFF=33, 0x00000=22, 0x00001=11.
- Misaligned word load from 0x00101:
  - Default build -> 0x??DEADBE, with the top byte from 0x104.
  - With `MEM_CTRL_MISALIGN_TRAP_EN` -> no RAM access; `done_o` and `err_o` on cycle 1; `rdata_o`=0.
- `rst_n` asserted during the 2nd byte of a word store -> `ram_wr_o` drops without a clock edge. After release, state is IDLE and the next request completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings, FSM state type and helpers for the byte-serial data-memory controller.
// Misalignment trapping is selected by MEM_CTRL_MISALIGN_TRAP_EN (see mem_ctrl.sv).
package mem_ctrl_pkg;

  localparam int RAM_ADDR_W_DEF = 17;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Index of the last byte of a request: 0, 1 or 3 (size 11 behaves as word).
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] lsb, input logic [1:0] size);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lsb[0];
      default: return (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load-data extender: zero/sign-extends a byte, half or word result to 32 bits.
module load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = raw;
    unique case (size)
      SIZE_B:  rdata = {{24{sign & raw[7]}}, raw[7:0]};
      SIZE_H:  rdata = {{16{sign & raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage data-memory responder: serialises loads/stores into little-endian byte RAM accesses.
// Optional build macro MEM_CTRL_MISALIGN_TRAP_EN rejects misaligned half/word requests with err_o.
//
// state    | meaning
// ST_IDLE  | waiting for req_i; latches the request on acceptance
// ST_WRITE | one RAM byte write per cycle, bytes 0..n-1
// ST_READ  | issue byte addresses, capture returned data one cycle later; tail = final capture
// ST_DONE  | one-cycle done_o pulse with extended load data
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  stall_o,
  output logic [RAM_ADDR_W-1:0] ram_a_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_wr_o,
  input  logic [7:0]            ram_din_i
);

  state_t                state, state_nx;
  logic [1:0]            cnt, cnt_nx;
  logic                  tail, tail_nx;
  logic [RAM_ADDR_W-1:0] addr;
  logic [1:0]            size;
  logic                  sign;
  logic                  store;
  logic                  err;
  logic [31:0]           wdata;
  logic [31:0]           result;
  logic [31:0]           ext_data;
  logic [1:0]            last;
  logic [1:0]            cap_idx;
  logic                  cap_en;
  logic                  accept;
  logic                  misalign;
  logic                  unused_addr;

  assign unused_addr = ^addr_i[31:RAM_ADDR_W];

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(addr_i[1:0], size_i);
`else
  assign misalign = 1'b0;
`endif

  assign last    = last_idx(size);
  assign accept  = (state == ST_IDLE) && req_i;
  // Capture lags issue by one cycle; in the tail cycle cnt holds at the last byte.
  assign cap_idx = tail ? cnt : cnt - 2'd1;
  assign cap_en  = (state == ST_READ) && (tail || (cnt != 2'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      tail  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tail  <= tail_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tail_nx  = tail;
    unique case (state)
      ST_IDLE: begin
        if (req_i) begin
          cnt_nx  = '0;
          tail_nx = 1'b0;
          if (misalign)  state_nx = ST_DONE;
          else if (we_i) state_nx = ST_WRITE;
          else           state_nx = ST_READ;
        end
      end
      ST_WRITE: begin
        if (cnt == last) state_nx = ST_DONE;
        else             cnt_nx   = cnt + 2'd1;
      end
      ST_READ: begin
        if (tail)             state_nx = ST_DONE;
        else if (cnt == last) tail_nx  = 1'b1;
        else                  cnt_nx   = cnt + 2'd1;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      size   <= SIZE_B;
      sign   <= 1'b0;
      store  <= 1'b0;
      err    <= 1'b0;
      wdata  <= '0;
      result <= '0;
    end else if (accept) begin
      addr   <= addr_i[RAM_ADDR_W-1:0];
      size   <= size_i;
      sign   <= sign_i;
      store  <= we_i;
      err    <= misalign;
      wdata  <= wdata_i;
      result <= '0;
    end else if (cap_en) begin
      result[{cap_idx, 3'b000} +: 8] <= ram_din_i;
    end
  end

  load_ext u_load_ext (
    .raw   (result),
    .size  (size),
    .sign  (sign),
    .rdata (ext_data)
  );

  // Outputs decode straight from state so reset drops the write enable without a clock.
  assign ram_wr_o   = (state == ST_WRITE);
  assign ram_a_o    = addr + RAM_ADDR_W'(cnt);
  assign ram_dout_o = ram_wr_o ? wdata[{cnt, 3'b000} +: 8] : 8'h00;
  assign done_o     = (state == ST_DONE);
  assign err_o      = done_o & err;
  assign rdata_o    = (done_o && !store && !err) ? ext_data : 32'h0;
  assign stall_o    = req_i & ~done_o;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic against a byte-array model.
module tb_mem_ctrl;

  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   addr = '0;
  logic [1:0]    size = '0;
  logic          sign = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          done, err, stall, ram_wr;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  logic [7:0] ram     [MSZ];
  logic [7:0] ref_mem [MSZ];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  mem_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .size_i     (size),
    .sign_i     (sign),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .done_o     (done),
    .err_o      (err),
    .stall_o    (stall),
    .ram_a_o    (ram_a),
    .ram_dout_o (ram_dout),
    .ram_wr_o   (ram_wr),
    .ram_din_i  (ram_din)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] raw, input int n, input bit sg);
    longint m, v;
    if (n == 4) return raw;
    m = longint'(1) << (8 * n);
    v = longint'(raw) % m;
    if (sg && v >= m / 2) v = v - m;
    return 32'(v);
  endfunction

  task automatic do_req(input bit w, input logic [31:0] a, input logic [1:0] sz, input bit sg,
                        input logic [31:0] wd, input string tag, output logic [31:0] got);
    int ra, n, lat, idx;
    bit mis, trap, seen;
    logic [31:0] raw, exp_rd;
    int ewr[$];
    int wlog[$];
    ra = int'(a[AW-1:0]);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    trap = TRAP && mis;
    lat = trap ? 1 : (w ? n + 1 : n + 2);
    raw = '0;
    exp_rd = '0;
    got = '0;
    seen = 1'b0;
    if (!trap) begin
      for (int i = 0; i < n; i++) begin
        idx = (ra + i) % MSZ;
        if (w) begin
          ewr.push_back(idx * 256 + int'(wd[8*i +: 8]));
          ref_mem[idx] = wd[8*i +: 8];
        end else begin
          raw[8*i +: 8] = ref_mem[idx];
        end
      end
      if (!w) exp_rd = ext(raw, n, sg);
    end

    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; size = sz; sign = sg; wdata = wd;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, " stall0"}, stall, 1'b1);
      if (ram_wr) wlog.push_back(int'(ram_a) * 256 + int'(ram_dout));
      if (done) begin
        chk({tag, " latency"}, c, lat);
        chk({tag, " rdata"}, rdata, exp_rd);
        chk({tag, " err"}, err, trap);
        chk({tag, " stall_done"}, stall, 1'b0);
        got = rdata;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
    chk({tag, " nwrites"}, wlog.size(), ewr.size());
    for (int i = 0; i < ewr.size() && i < wlog.size(); i++)
      chk({tag, " wr_addr_data"}, wlog[i], ewr[i]);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    logic [31:0] a;
    for (int i = 0; i < MSZ; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      ref_mem[i] = b;
    end

    #3;
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst ram_wr", ram_wr, 1'b0);
    chk("rst ram_a", 32'(ram_a), 32'h0);
    chk("rst ram_dout", ram_dout, 8'h00);
    chk("rst stall", stall, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_req(1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF, "st_w100", r);
    do_req(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, "ld_w100", r);
    chk("ld_w100 const", r, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0, "ld_b103s", r);
    chk("ld_b103s const", r, 32'hFFFF_FFDE);
    do_req(1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0, "ld_b103u", r);
    chk("ld_b103u const", r, 32'h0000_00DE);
    do_req(1'b0, 32'h0000_0102, 2'b01, 1'b1, 32'h0, "ld_h102s", r);
    chk("ld_h102s const", r, 32'hFFFF_DEAD);
    do_req(1'b1, 32'h0001_FFFE, 2'b10, 1'b0, 32'h1122_3344, "st_wrap", r);
    do_req(1'b0, 32'h0001_FFFE, 2'b10, 1'b0, 32'h0, "ld_wrap", r);
    do_req(1'b0, 32'h0000_0101, 2'b10, 1'b0, 32'h0, "ld_mis101", r);
    do_req(1'b0, 32'hFFF0_0100, 2'b11, 1'b0, 32'h0, "ld_hibits", r);
    do_req(1'b1, 32'h0000_0105, 2'b01, 1'b0, 32'hAAAA_8001, "st_mis_h", r);
    do_req(1'b0, 32'h0000_0104, 2'b10, 1'b1, 32'h0, "ld_w104", r);

    // Abandon a word store during its second byte
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h0000_0200; size = 2'b10; sign = 1'b0; wdata = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    chk("rst_mid wr_before", ram_wr, 1'b1);
    chk("rst_mid addr_before", 32'(ram_a), 32'h201);
    rst_n = 1'b0;
    #1;
    chk("rst_mid wr", ram_wr, 1'b0);
    chk("rst_mid done", done, 1'b0);
    chk("rst_mid ram_a", 32'(ram_a), 32'h0);
    chk("rst_mid dout", ram_dout, 8'h00);
    req = 1'b0;
    ref_mem[32'h200] = 8'h0D;
    @(posedge clk); #1 rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0, "ld_after_rst", r);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom;
        1:       a = {15'($urandom), 17'h1FFFC} + 32'($urandom_range(0, 3));
        default: a = 32'h100 + 32'($urandom_range(0, 15));
      endcase
      do_req(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, "rand", r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
